pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch stage of the single-cycle RISC-V core; sits directly upstream of instruction_memory.
//  Drives inst_addr = PC combinationally and captures the returned 32-bit word into a fetch register (if_*).
//  Applies the next-PC choice: PC+4, branch target or jump target. Supports downstream stall and detects faults.
//  Fault cases are a misaligned PC or a PC outside the memory range; on a fault the block halts.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  IMEM_BYTES  16             instruction memory size in bytes; a PC is valid only if PC+3 < IMEM_BYTES
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high reset
//  inst_addr      out  32  byte address to instruction_memory, always equal to pc
//  instruction    in   32  word returned combinationally by instruction_memory for inst_addr
//  stall          in   1   downstream not ready; hold pc and if_* registers
//  branch_taken   in   1   redirect to branch_target
//  branch_target  in   32  branch destination
//  jump           in   1   redirect to jump_target (JAL/JALR)
//  jump_target    in   32  jump destination
//  if_valid       out  1   if_instr/if_pc hold a live instruction
//  if_pc          out  32  PC of if_instr
//  if_pc_plus4    out  32  if_pc + 4 (link value)
//  if_instr       out  32  fetched instruction word
//  fault          out  1   sticky fetch fault
//  fault_pc       out  32  offending PC
// BEHAVIOUR
//  Reset values
//   - pc=RESET_PC; state=BOOT; if_valid=0; if_pc=0; if_instr=NOP (32'h0000_0013).
//   - if_pc_plus4=4; fault=0; fault_pc=0.
//  FSM: BOOT -> RUN -> HALT. Only reset leaves HALT.
//   - BOOT: one cycle; if_valid=0; pc holds; go to RUN.
//   - RUN, bad pc (pc[1:0]!=0 or pc+3 >= IMEM_BYTES)
//     - next state: HALT.
//     - outputs: fault<=1, fault_pc<=pc, if_valid<=0, if_instr<=NOP.
//     - Checked before redirect/stall.
//   - RUN, jump=1: pc<=jump_target; if_valid<=0; if_instr<=NOP. Jump beats branch when both are set.
//   - RUN, branch_taken=1 (jump=0): pc<=branch_target; if_valid<=0; if_instr<=NOP.
//   - RUN, stall=1, no redirect: pc and all if_* hold their values.
//   - RUN, otherwise
//     - if_instr<=instruction, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1.
//     - pc<=pc+4, modulo 2^32.
//   - Redirect overrides stall: the held instruction is flushed.
//   - HALT: pc, fault and fault_pc hold; if_valid=0; redirect and stall inputs are ignored.
//  Timing
//   - Latency: word at address A appears on if_instr one cycle after inst_addr=A.
//   - Redirect penalty: one bubble. The target's word is valid two cycles after the redirect cycle.
//  A misaligned target is accepted into pc and then faults on the next RUN cycle.
//  Reset asserted in any state, mid-stall or mid-redirect, wins and restores all reset values on the next edge.
// STRUCTURE
//  Shared package riscv_pkg holds:
//   - XLEN=32, INSTR_NOP=32'h0000_0013;
//   - fetch_state_t {BOOT,RUN,HALT};
//   - the default RESET_PC.
//  One sub-module is natural: next_pc_sel, the combinational priority mux (fault > jump > branch > stall > +4).
//  The PC, FSM and fetch registers stay in pc_fetch_unit.
// TESTING  (imem words @0,4,8,12 = FFC4A303, 0064A423, 0062E233, FE420AE3)
//  1 Reset 2 cycles, release
//    - inst_addr=0 and if_valid=0 in BOOT.
//    - Then consecutive if_instr values FFC4A303, 0064A423, 0062E233, FE420AE3 with if_pc=0,4,8,12.
//  2 Run past 12 with no redirect
//    - pc=16: fault=1, fault_pc=0x10, if_valid=0, and the block stays halted.
//  3 branch_taken=1, target=0, in the cycle pc=12
//    - One bubble (if_valid=0), then if_instr=FFC4A303 with if_pc=0.
//  4 stall=1 for 3 cycles while if_pc=4
//    - if_instr stays 0064A423 and inst_addr stays 8.
//    - On release, if_pc=8.
//  5 jump=1 (target=8) and branch_taken=1 (target=4) in the same cycle
//    - Next valid if_pc=8.
//    - Repeat with stall=1 also set: the redirect still wins.
//  6 jump to target 0x2
//    - Next cycle enters HALT: fault=1, fault_pc=0x2.
//    - A later reset clears fault and refetches from 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage of the single-cycle RISC-V core.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   XLEN, INSTR_NOP, DEFAULT_RESET_PC  - core-wide constants
//   fetch_state_t                      - fetch FSM states (BOOT -> RUN -> HALT)
//   fetch_sel_t                        - per-cycle action picked by the next-PC mux
//   pc_is_bad()                        - misalignment / out-of-range PC test
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Action chosen for the current cycle, in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,   // not in RUN: nothing fetched
        SEL_FAULT  = 3'd1,   // bad pc: enter HALT
        SEL_JUMP   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_STALL  = 3'd4,
        SEL_SEQ    = 3'd5    // normal sequential fetch
    } fetch_sel_t;

    // A pc is usable only when word-aligned and the whole word fits in memory.
    // The sum is done two bits wider so a pc near 2^32 cannot wrap into range.
    function automatic logic pc_is_bad(input logic [XLEN-1:0] pc,
                                       input int unsigned imem_bytes);
        logic [XLEN+1:0] last_byte;
        last_byte = {2'b00, pc} + (XLEN+2)'(3);
        return (pc[1:0] != 2'b00) || (last_byte >= (XLEN+2)'(imem_bytes));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational priority mux for the next PC: fault > jump > branch > stall > +4.
// Latency: zero cycles (purely combinational).
// Backpressure: stall only selects "hold"; any redirect overrides it.
//
// Ports:
//   run           in   1     fetch FSM is in RUN
//   pc_bad        in   1     current pc is misaligned or out of range
//   pc            in   XLEN  current pc
//   jump          in   1     jump redirect request
//   jump_target   in   XLEN  jump destination
//   branch_taken  in   1     branch redirect request
//   branch_target in   XLEN  branch destination
//   stall         in   1     downstream not ready
//   sel           out  3     chosen action (fetch_sel_t)
//   next_pc       out  XLEN  pc value for the next cycle
//   pc_plus4      out  XLEN  pc + 4, modulo 2^XLEN
module next_pc_sel
    import riscv_pkg::*;
(
    input  logic            run,
    input  logic            pc_bad,
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output fetch_sel_t      sel,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        sel     = SEL_HOLD;
        next_pc = pc;
        if (!run) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (pc_bad) begin
            // The fault check sees the pc being presented now, so it wins
            // over any redirect or stall arriving in the same cycle.
            sel     = SEL_FAULT;
            next_pc = pc;
        end else if (jump) begin
            sel     = SEL_JUMP;
            next_pc = jump_target;
        end else if (branch_taken) begin
            sel     = SEL_BRANCH;
            next_pc = branch_target;
        end else if (stall) begin
            sel     = SEL_STALL;
            next_pc = pc;
        end else begin
            sel     = SEL_SEQ;
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch register of the single-cycle RISC-V core.
// Latency: word at inst_addr=A appears on if_instr one cycle later; a redirect costs one bubble.
// Backpressure: stall holds pc and all if_* registers; a redirect flushes the held word.
//
// Ports:
//   clk, reset     single rising-edge clock, synchronous active-high reset
//   inst_addr      out  byte address to instruction memory (always pc)
//   instruction    in   word returned combinationally for inst_addr
//   stall          in   hold pc and fetch register
//   branch_taken / branch_target, jump / jump_target   redirect requests (jump wins)
//   if_valid, if_pc, if_pc_plus4, if_instr             fetch register outputs
//   fault, fault_pc                                    sticky fault flag and offending pc
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     IMEM_BYTES = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] inst_addr,
    input  logic [XLEN-1:0] instruction,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_instr,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            pc_bad;
    fetch_sel_t      sel;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;

    assign inst_addr = pc;
    assign pc_bad    = pc_is_bad(pc, IMEM_BYTES);

    next_pc_sel u_next_pc_sel (
        .run           (state == RUN),
        .pc_bad        (pc_bad),
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .sel           (sel),
        .next_pc       (next_pc),
        .pc_plus4      (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus4 <= XLEN'(4);
            if_instr    <= INSTR_NOP;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    // One idle cycle so the first fetch sees a settled pc.
                    state    <= RUN;
                    if_valid <= 1'b0;
                end
                RUN: begin
                    pc <= next_pc;
                    case (sel)
                        SEL_FAULT: begin
                            state    <= HALT;
                            fault    <= 1'b1;
                            fault_pc <= pc;
                            if_valid <= 1'b0;
                            if_instr <= INSTR_NOP;
                        end
                        SEL_JUMP, SEL_BRANCH: begin
                            // The word fetched this cycle belongs to the
                            // wrong path: squash it into a bubble.
                            if_valid <= 1'b0;
                            if_instr <= INSTR_NOP;
                        end
                        SEL_SEQ: begin
                            if_valid    <= 1'b1;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                            if_instr    <= instruction;
                        end
                        default: begin
                            // SEL_STALL: everything holds.
                        end
                    endcase
                end
                HALT: begin
                    if_valid <= 1'b0;
                end
                default: begin
                    state    <= HALT;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        fault;
    logic [31:0] fault_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic stall_at_edge;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_addr     (inst_addr),
        .instruction   (instruction),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        if (addr >= 32'd16) return 32'h0000_0000;
        case (addr[3:2])
            2'd0:    return 32'hFFC4A303;
            2'd1:    return 32'h0064A423;
            2'd2:    return 32'h0062E233;
            default: return 32'hFE420AE3;
        endcase
    endfunction

    assign instruction = imem_word(inst_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = imem_word(pc);
        sb_q.push_back(e);
    endtask

    // One clock: inputs applied before the edge take effect at it; outputs are
    // sampled 1 time unit later. A fresh valid word is popped and compared.
    task automatic step();
        exp_t e;
        stall_at_edge = stall;
        @(posedge clk);
        #1;
        if (if_valid === 1'b1 && !stall_at_edge && !reset) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_if_pc", if_pc, e.pc);
                check("sb_if_instr", if_instr, e.instr);
                check("sb_if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            end
        end
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        clear_ctrl();
        reset = 1'b1;

        // 1: reset values, BOOT, then four sequential fetches
        do_reset();
        check("rst_inst_addr", inst_addr, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, INSTR_NOP);
        check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        step();  // BOOT -> RUN
        check("boot_if_valid", {31'b0, if_valid}, 32'h0);
        check("boot_inst_addr", inst_addr, 32'h0);
        for (int a = 0; a < 16; a += 4) expect_fetch(32'(a));
        for (int i = 0; i < 4; i++) step();
        check("seq_inst_addr", inst_addr, 32'h10);

        // 2: pc=16 faults and halts; redirects ignored afterwards
        step();
        check("oob_fault", {31'b0, fault}, 32'h1);
        check("oob_fault_pc", fault_pc, 32'h10);
        check("oob_if_valid", {31'b0, if_valid}, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h0;
        for (int i = 0; i < 3; i++) step();
        clear_ctrl();
        check("halt_inst_addr", inst_addr, 32'h10);
        check("halt_fault", {31'b0, fault}, 32'h1);
        check("halt_if_valid", {31'b0, if_valid}, 32'h0);

        // 3: branch to 0 while pc=12
        do_reset();
        check("rst2_fault", {31'b0, fault}, 32'h0);
        step();
        for (int a = 0; a < 12; a += 4) expect_fetch(32'(a));
        for (int i = 0; i < 3; i++) step();
        check("br_pc_before", inst_addr, 32'hC);
        branch_taken = 1'b1; branch_target = 32'h0;
        step();
        clear_ctrl();
        check("br_bubble", {31'b0, if_valid}, 32'h0);
        check("br_inst_addr", inst_addr, 32'h0);
        expect_fetch(32'h0);
        step();

        // 4: stall three cycles while if_pc=4
        expect_fetch(32'h4);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_if_instr", if_instr, 32'h0064A423);
            check("stall_inst_addr", inst_addr, 32'h8);
            check("stall_if_pc", if_pc, 32'h4);
        end
        stall = 1'b0;
        expect_fetch(32'h8);
        step();

        // 5: jump and branch together; jump wins, also over stall
        jump = 1'b1; jump_target = 32'h8;
        branch_taken = 1'b1; branch_target = 32'h4;
        step();
        clear_ctrl();
        check("jb_bubble", {31'b0, if_valid}, 32'h0);
        check("jb_inst_addr", inst_addr, 32'h8);
        expect_fetch(32'h8);
        step();
        jump = 1'b1; jump_target = 32'h8;
        branch_taken = 1'b1; branch_target = 32'h4;
        stall = 1'b1;
        step();
        clear_ctrl();
        check("jbs_bubble", {31'b0, if_valid}, 32'h0);
        check("jbs_inst_addr", inst_addr, 32'h8);
        expect_fetch(32'h8);
        step();

        // 6: misaligned jump target accepted, then faults
        jump = 1'b1; jump_target = 32'h2;
        step();
        clear_ctrl();
        check("mis_accept_pc", inst_addr, 32'h2);
        check("mis_no_fault_yet", {31'b0, fault}, 32'h0);
        step();
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_fault_pc", fault_pc, 32'h2);
        check("mis_if_valid", {31'b0, if_valid}, 32'h0);
        do_reset();
        check("rst3_fault", {31'b0, fault}, 32'h0);
        check("rst3_inst_addr", inst_addr, 32'h0);
        step();
        expect_fetch(32'h0);
        step();

        // Reset asserted mid-stall wins
        stall = 1'b1;
        reset = 1'b1;
        step();
        check("rst_mid_stall_valid", {31'b0, if_valid}, 32'h0);
        check("rst_mid_stall_instr", if_instr, INSTR_NOP);
        reset = 1'b0;
        clear_ctrl();

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
